// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared constants and helpers for the MiniMIPS32 writeback stage.
//   REG_ADDR_BUS / REG_BUS : register address and data widths
//   ZERO_WORD, WRITE_ENABLE: common literal values
//   BE_*                   : byte-lane enable patterns of legal loads
//   ext_byte / ext_half    : sub-word extension to a full register word
package wb_stage_pkg;

   localparam int unsigned REG_ADDR_BUS = 5;
   localparam int unsigned REG_BUS      = 32;

   localparam logic [REG_BUS-1:0] ZERO_WORD    = '0;
   localparam logic               WRITE_ENABLE = 1'b1;

   localparam logic [3:0] BE_WORD  = 4'b1111;
   localparam logic [3:0] BE_HALF0 = 4'b0011;
   localparam logic [3:0] BE_HALF1 = 4'b1100;
   localparam logic [3:0] BE_B0    = 4'b0001;
   localparam logic [3:0] BE_B1    = 4'b0010;
   localparam logic [3:0] BE_B2    = 4'b0100;
   localparam logic [3:0] BE_B3    = 4'b1000;

   function automatic logic [REG_BUS-1:0] ext_byte(input logic [7:0] b, input logic sext);
      return {{(REG_BUS-8){sext & b[7]}}, b};
   endfunction

   function automatic logic [REG_BUS-1:0] ext_half(input logic [15:0] h, input logic sext);
      return {{(REG_BUS-16){sext & h[15]}}, h};
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: little-endian load alignment and extension (combinational).
//   dm   in  32  data-memory read word
//   dre  in  4   byte-lane enables of the load
//   sext in  1   1 = sign-extend sub-word loads, 0 = zero-extend
//   data out 32  aligned, extended load value (zero when pattern is illegal)
//   ok   out 1   lane pattern is one of the legal load shapes
module wb_load_align
   import wb_stage_pkg::*;
(
   input  logic [REG_BUS-1:0] dm,
   input  logic [3:0]         dre,
   input  logic               sext,
   output logic [REG_BUS-1:0] data,
   output logic               ok
);

   always_comb begin
      data = ZERO_WORD;
      ok   = 1'b1;
      case (dre)
         BE_WORD:  data = dm;
         BE_B0:    data = ext_byte(dm[7:0],   sext);
         BE_B1:    data = ext_byte(dm[15:8],  sext);
         BE_B2:    data = ext_byte(dm[23:16], sext);
         BE_B3:    data = ext_byte(dm[31:24], sext);
         BE_HALF0: data = ext_half(dm[15:0],  sext);
         BE_HALF1: data = ext_half(dm[31:16], sext);
         default:  ok   = 1'b0;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback unit; sole driver of the
// register-file write port. The pipeline slot has priority over a one-entry
// divider result buffer.
//   cpu_clk_50M, cpu_rst (sync, active-high)
//   stall, flush                          : pipeline control
//   mem_wa/wreg/dreg/mreg/dre/sext        : memory-stage result
//   dm                                    : data-memory read word (WB cycle)
//   div_valid/div_wa/div_wd, div_ready    : divider result handshake
//   wa, wd, we                            : register-file write port
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = REG_ADDR_BUS,
   parameter int unsigned DATA_W = REG_BUS
)(
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] mem_wa,
   input  logic              mem_wreg,
   input  logic [DATA_W-1:0] mem_dreg,
   input  logic              mem_mreg,
   input  logic [3:0]        mem_dre,
   input  logic              mem_sext,
   input  logic [DATA_W-1:0] dm,
   input  logic              div_valid,
   input  logic [ADDR_W-1:0] div_wa,
   input  logic [DATA_W-1:0] div_wd,
   output logic              div_ready,
   output logic [ADDR_W-1:0] wa,
   output logic [DATA_W-1:0] wd,
   output logic              we
);

   // MEM/WB stage register
   logic [ADDR_W-1:0] s_wa;
   logic              s_wreg;
   logic [DATA_W-1:0] s_dreg;
   logic              s_mreg;
   logic [3:0]        s_dre;
   logic              s_sext;
   logic              s_done;   // held instruction already wrote during this stall

   // divider result buffer
   logic              bv;
   logic [ADDR_W-1:0] bwa;
   logic [DATA_W-1:0] bwd;

   logic [DATA_W-1:0] ld_data;
   logic              ld_ok;
   logic [DATA_W-1:0] slot_data;
   logic              slot_req;
   logic              buf_req;

   wb_load_align u_align (
      .dm   (dm),
      .dre  (s_dre),
      .sext (s_sext),
      .data (ld_data),
      .ok   (ld_ok)
   );

   assign slot_data = s_mreg ? ld_data : s_dreg;
   // Writes are suppressed during reset so the port is quiet in the reset cycle
   // regardless of what the registers held beforehand.
   assign slot_req  = !cpu_rst && s_wreg && (s_wa != '0) && !s_done && (!s_mreg || ld_ok);
   assign buf_req   = !cpu_rst && !slot_req && bv && (bwa != '0);
   assign div_ready = !bv && !cpu_rst;

   always_comb begin
      we = 1'b0;
      wa = '0;
      wd = '0;
      if (slot_req) begin
         we = WRITE_ENABLE;
         wa = s_wa;
         wd = slot_data;
      end else if (buf_req) begin
         we = WRITE_ENABLE;
         wa = bwa;
         wd = bwd;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst || flush) begin
         s_wa   <= '0;
         s_wreg <= 1'b0;
         s_dreg <= '0;
         s_mreg <= 1'b0;
         s_dre  <= '0;
         s_sext <= 1'b0;
         s_done <= 1'b0;
      end else if (!stall) begin
         s_wa   <= mem_wa;
         s_wreg <= mem_wreg;
         s_dreg <= mem_dreg;
         s_mreg <= mem_mreg;
         s_dre  <= mem_dre;
         s_sext <= mem_sext;
         s_done <= 1'b0;
      end else if (slot_req) begin
         s_done <= 1'b1;
      end
   end

   // Capture only when empty, so capture and drain never coincide. An entry
   // leaves when the port is free (written, or dropped if bwa is r0) or when a
   // younger slot write to the same register overrides it.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         bv  <= 1'b0;
         bwa <= '0;
         bwd <= '0;
      end else if (div_valid && div_ready) begin
         bv  <= 1'b1;
         bwa <= div_wa;
         bwd <= div_wd;
      end else if (bv && (!slot_req || (s_wa == bwa))) begin
         bv  <= 1'b0;
      end
   end

endmodule
